// File: rtl/exp_series_ctrl.sv
// Horner-rule sequencer for truncated exp(x): reads coefficients N..0 from ROM and chains acc*x+c FMA ops.
// Define FMA_TIMEOUT_EN to abort with err when the FMA stalls for TIMEOUT_CYCLES in ISSUE or WAIT_RES.
module exp_series_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int NUM_COEFF      = 33,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [ADDR_WIDTH-1:0] num_terms,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  fma_valid,
    input  logic                  fma_ready,
    output logic [DATA_WIDTH-1:0] fma_a,
    output logic [DATA_WIDTH-1:0] fma_b,
    output logic [DATA_WIDTH-1:0] fma_c,
    input  logic                  fma_res_valid,
    input  logic [DATA_WIDTH-1:0] fma_res
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CAP, S_ISSUE, S_WAIT_RES, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(NUM_COEFF - 1);

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_x, r_acc, r_coeff, r_result;
    logic [ADDR_WIDTH-1:0] r_k;
    logic                  r_first, r_err;
    logic                  w_n_oob, w_timeout;

    assign w_n_oob = (num_terms > MAX_IDX);

`ifdef FMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          w_in_fma;

    assign w_in_fma  = (r_state == S_ISSUE) || (r_state == S_WAIT_RES);
    assign w_timeout = w_in_fma && (r_tmo == TW'(TIMEOUT_CYCLES));

    // Restarts from zero on every entry into ISSUE or WAIT_RES.
    always_ff @(posedge clk) begin
        if (rst || !w_in_fma || (w_next != r_state))
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 1'b1;
    end
`else
    // Watchdog compiled out: a non-negative limit never fires.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        rom_rd    = 1'b0;
        fma_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = w_n_oob ? S_DONE : S_RD;
            end
            S_RD: begin
                rom_rd = 1'b1;
                w_next = S_CAP;
            end
            S_CAP: begin
                if (!r_first)
                    w_next = S_ISSUE;
                else if (r_k == '0)
                    w_next = S_DONE;
                else
                    w_next = S_RD;
            end
            S_ISSUE: begin
                fma_valid = 1'b1;
                if (fma_ready)
                    w_next = S_WAIT_RES;
                else if (w_timeout)
                    w_next = S_DONE;
            end
            S_WAIT_RES: begin
                if (fma_res_valid)
                    w_next = (r_k == '0) ? S_DONE : S_RD;
                else if (w_timeout)
                    w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // result is loaded on the transition into DONE so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_acc    <= '0;
            r_coeff  <= '0;
            r_result <= '0;
            r_k      <= '0;
            r_first  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= x_in;
                        r_k     <= num_terms;
                        r_first <= 1'b1;
                        r_err   <= w_n_oob;
                        if (w_n_oob)
                            r_result <= '0;
                    end
                end
                S_CAP: begin
                    if (r_first) begin
                        r_acc   <= rom_data;
                        r_first <= 1'b0;
                        if (r_k == '0)
                            r_result <= rom_data;
                        else
                            r_k <= r_k - 1'b1;
                    end else begin
                        r_coeff <= rom_data;
                    end
                end
                S_ISSUE: begin
                    if (!fma_ready && w_timeout) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end
                end
                S_WAIT_RES: begin
                    if (fma_res_valid) begin
                        r_acc <= fma_res;
                        if (r_k == '0)
                            r_result <= fma_res;
                        else
                            r_k <= r_k - 1'b1;
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign rom_addr = r_k;
    assign fma_a    = r_acc;
    assign fma_b    = r_x;
    assign fma_c    = r_coeff;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// Randomized bench for exp_series_ctrl: ROM and FMA responders plus a Horner reference model.
// The FMA stand-in computes a*b+c modulo 2^32 so every chained value is exactly predictable.
module tb_exp_series_ctrl;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] x_in;
    logic [5:0]  num_terms;
    logic        busy, done, err, rom_rd, fma_valid, fma_ready, fma_res_valid;
    logic [31:0] result, rom_data, fma_a, fma_b, fma_c, fma_res;
    logic [5:0]  rom_addr;

    exp_series_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .num_terms(num_terms),
        .busy(busy), .done(done), .result(result), .err(err),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .fma_valid(fma_valid), .fma_ready(fma_ready),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_res_valid(fma_res_valid), .fma_res(fma_res)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] rom [33];
    int          addr_q[$];
    logic [95:0] op_q[$];
    int          done_cnt = 0;
    int          stall_left = 0;
    int          lat_fixed = 0;
    bit          ready_hi = 1'b0;
    logic [95:0] hold;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered ROM: data appears the cycle after the read strobe.
    initial begin
        rom_data = '0;
        forever begin
            @(negedge clk);
            if (rom_rd) begin
                addr_q.push_back(int'(rom_addr));
                rom_data = (rom_addr < 6'd33) ? rom[rom_addr] : 32'hdeadbeef;
            end
            if (done) done_cnt++;
        end
    end

    // FMA responder: random ready, random latency 1..4 unless pinned.
    initial begin
        int          pend_cnt;
        logic [31:0] pend_res;
        pend_cnt      = 0;
        pend_res      = '0;
        fma_ready     = 1'b0;
        fma_res_valid = 1'b0;
        fma_res       = '0;
        forever begin
            @(negedge clk);
            fma_res_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    fma_res_valid = 1'b1;
                    fma_res       = pend_res;
                end
            end
            fma_ready = ready_hi ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (fma_valid && stall_left > 0) begin
                fma_ready = 1'b0;
                if (stall_left == 5) hold = {fma_a, fma_b, fma_c};
                else check_eq("stall_hold", {fma_a, fma_b, fma_c}, hold);
                stall_left--;
            end
            if (fma_valid && fma_ready) begin
                check_eq("one_outstanding", pend_cnt, 0);
                op_q.push_back({fma_a, fma_b, fma_c});
                pend_res = fma_a * fma_b + fma_c;
                pend_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
            end
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [5:0] n, input int exp_lat, input bit poke);
        int          cyc;
        int          nn;
        bit          oob;
        logic [31:0] acc;
        logic [95:0] ops[$];
        addr_q.delete();
        op_q.delete();
        done_cnt  = 0;
        start     = 1'b1;
        x_in      = x;
        num_terms = n;
        @(negedge clk);
        start     = 1'b0;
        x_in      = $urandom;
        num_terms = 6'($urandom);
        check_eq("busy_after_start", busy, 1);
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 4);
        end
        start = 1'b0;
        check_eq("done_seen", done, 1);
        if (exp_lat > 0) check_eq("latency", cyc, exp_lat);
        nn  = int'(n);
        oob = (nn > 32);
        check_eq("err", err, oob);
        acc = '0;
        if (!oob) begin
            acc = rom[nn];
            for (int k = nn - 1; k >= 0; k--) begin
                ops.push_back({acc, x, rom[k]});
                acc = acc * x + rom[k];
            end
        end
        check_eq("result", result, acc);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_after", busy, 0);
        check_eq("done_count", done_cnt, 1);
        check_eq("rd_count", addr_q.size(), oob ? 0 : nn + 1);
        for (int i = 0; i < addr_q.size() && i <= nn; i++)
            check_eq("rd_addr", addr_q[i], nn - i);
        check_eq("fma_count", op_q.size(), ops.size());
        for (int i = 0; i < ops.size() && i < op_q.size(); i++)
            check_eq("fma_op", op_q[i], ops[i]);
        check_eq("result_held", result, acc);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst       = 1'b1;
        start     = 1'b0;
        x_in      = '0;
        num_terms = '0;
        for (int i = 0; i < 33; i++) rom[i] = $urandom;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", {busy, done, err, rom_rd, fma_valid}, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_fma_ops", {fma_a, fma_b, fma_c}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'h3f800000, 6'd0, 3, 1'b0);

        rom[0] = 32'h3f800000; rom[1] = 32'h3f800000; rom[2] = 32'h3f000000;
        lat_fixed = 2; ready_hi = 1'b1;
        run_op(32'h3f800000, 6'd2, 0, 1'b0);
        lat_fixed = 0; ready_hi = 1'b0;

        run_op($urandom, 6'd33, 1, 1'b0);
        run_op($urandom, 6'd63, 1, 1'b0);

        stall_left = 5;
        run_op($urandom, 6'd3, 0, 1'b1);
        check_eq("stall_consumed", stall_left, 0);

        // Reset while waiting on an FMA result.
        lat_fixed = 4;
        addr_q.delete(); op_q.delete(); done_cnt = 0;
        start = 1'b1; x_in = $urandom; num_terms = 6'd5;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (op_q.size() == 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_eq("rst_reached_fma", op_q.size(), 1);
        @(negedge clk);
        check_eq("rst_in_wait", {busy, fma_valid}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_abort_ctrl", {busy, fma_valid, done}, 0);
        check_eq("rst_abort_result", result, 0);
        repeat (6) @(negedge clk);
        check_eq("rst_no_done", done_cnt, 0);
        lat_fixed = 0;
        run_op($urandom, 6'd4, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (i % 7 == 6) run_op($urandom, 6'($urandom_range(33, 63)), 1, 1'b0);
            else            run_op($urandom, 6'($urandom_range(0, 32)), 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/exp_series_ctrl.md
Name: exp_series_ctrl

Overview:
Sequencer that evaluates the truncated exp(x) Taylor series by Horner's rule: result = c0 + x*(c1 + x*(c2 + ... x*cN)).
- Drives the read port of the coefficient ROM, which holds 1/k! in IEEE-754 single precision and has 1-cycle registered read latency.
- Issues fused multiply-add operations to an external FP FMA unit over a valid/ready handshake.
- Returns the final sum with a done pulse.
- Sits between the accelerator command front-end and the coefficient ROM / FMA datapath.

Parameters:
DATA_WIDTH, 32, operand/coefficient width (IEEE-754 single)
ADDR_WIDTH, 6, ROM address and term-index width
NUM_COEFF, 33, ROM depth; valid indices 0..NUM_COEFF-1
TIMEOUT_CYCLES, 64, FMA watchdog limit (used only with FMA_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
x_in  in  DATA_WIDTH  series argument x; latched on accepted start
num_terms  in  ADDR_WIDTH  highest term index N; latched on accepted start
busy  out  1  high from the cycle after an accepted start through DONE
done  out  1  single-cycle completion pulse
result  out  DATA_WIDTH  final sum; held until the next accepted start
err  out  1  qualifies done; set for an out-of-range N or a timeout
rom_rd  out  1  ROM read strobe
rom_addr  out  ADDR_WIDTH  ROM read address
rom_data  in  DATA_WIDTH  ROM output; valid the cycle after rom_rd
fma_valid  out  1  FMA request valid
fma_ready  in  1  FMA accepts request when fma_valid && fma_ready
fma_a, fma_b, fma_c  out  DATA_WIDTH each  operands; FMA computes a*b+c (a=acc, b=x, c=coeff)
fma_res_valid  in  1  FMA result strobe
fma_res  in  DATA_WIDTH  FMA result

Behaviour:
- Reset (synchronous, active-high): state=IDLE. busy, done, err, rom_rd, fma_valid are 0. result, rom_addr, fma_a/b/c are 0. Internal acc and k are cleared.
- Reset mid-operation aborts the sequence with no done pulse. Outputs take reset values on the next edge.
- States: IDLE, RD, CAP, ISSUE, WAIT_RES, DONE.
- IDLE:
  - On start: latch x and N; set k=N and first=1.
  - If N > NUM_COEFF-1: go to DONE with err=1 and result=0. No ROM reads and no FMA ops are issued.
  - Otherwise go to RD.
  - start is ignored in every state other than IDLE.
- RD: rom_rd=1, rom_addr=k for exactly one cycle, then go to CAP.
- CAP (ROM data valid in this cycle):
  - If first: acc<=rom_data and first<=0. If k==0 go to DONE; else k<=k-1 and go to RD.
  - If not first: coeff<=rom_data and go to ISSUE.
- ISSUE:
  - fma_valid=1 with fma_a=acc, fma_b=x, fma_c=coeff.
  - fma_valid and all operands stay stable until the handshake completes.
  - On fma_valid && fma_ready go to WAIT_RES; fma_valid drops the next cycle.
- WAIT_RES:
  - On fma_res_valid: acc<=fma_res. If k==0 go to DONE; else k<=k-1 and go to RD.
  - fma_res_valid in any other state is ignored.
- DONE: done=1 for one cycle, result<=acc (or 0 on error), err valid alongside done. Then go to IDLE.
- Operation counts for N in range: exactly N+1 ROM reads at addresses N, N-1, ..., 0, and exactly N FMA requests.
- N=0 latency: start sampled in cycle T; rom_rd in T+1; done in T+3 with result=c0.
- Per-term cost after the first term: RD + CAP + ISSUE (≥1 cycle) + WAIT_RES (FMA latency).
- At most one FMA op is outstanding at any time. The controller performs no arithmetic; all FP operations happen in the FMA unit.

Optional Feature:
FMA_TIMEOUT_EN
- Defined: a counter runs while in ISSUE or WAIT_RES and clears on each state entry.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and result=0.
  - A late fma_res_valid arriving in IDLE is ignored.
- Not defined: no counter; the controller waits indefinitely. err is set only for an out-of-range N.

Test Plan:
- N=0, x=3f800000, start at T -> rom_rd only at T+1 with addr 0; done at T+3; result=3f800000; err=0; fma_valid never asserted.
- N=2, x=3f800000, FMA model with 2-cycle latency and ready held high -> ROM addresses 2,1,0 in order; FMA ops (3f000000, 3f800000, 3f800000) then (3fc00000, 3f800000, 3f800000); result=40200000 (2.5); exactly one done pulse.
- num_terms=33 -> done and err in cycle T+1; result=00000000; no rom_rd or fma_valid activity.
- fma_ready held low for 5 cycles during ISSUE -> fma_valid and fma_a/b/c stay constant for all 5 cycles; a second start pulse sent while busy is ignored.
- FMA_TIMEOUT_EN, TIMEOUT_CYCLES=64, fma_res_valid never asserted -> done and err once the counter reaches 64 in WAIT_RES; result=0; returns to IDLE.
- rst asserted for 1 cycle during WAIT_RES -> next cycle busy=0, fma_valid=0, result=0, no done pulse; a new start then completes normally.
